// File: rtl/memory_arbiter.sv
// Shares one single-port RAM between the instruction and data ports, one latched request at a time.
// Latency: grant 1 cycle, then RAM service until ACCESS, then a 1-cycle wait-low response (min 3 cycles).
// Backpressure: requesters hold until wait pulses low; data wins ties unless ARB_ROUND_ROBIN_EN is defined.
module memory_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        arb_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISERV = 3'd1,
        DSERV = 3'd2,
        IRESP = 3'd3,
        DRESP = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam logic [1:0]       RAM_ACCESS = 2'd2;
    localparam logic [1:0]       RAM_ERROR  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       store_q, store_d;
    logic [31:0]       iload_q, iload_d;
    logic [31:0]       dload_q, dload_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              d_req;
    logic              pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;
    logic last_grant_q, last_grant_d;

    // On contention the port that was not served last gets the grant.
    assign pick_d = d_req && (!iREN || (last_grant_q == GRANT_I));
`else
    assign pick_d = d_req;
`endif

    assign d_req = dREN | dWEN;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        store_d = store_q;
        iload_d = iload_q;
        dload_d = dload_q;
        cnt_d   = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_d) begin
                    wr_d    = dWEN;
                    addr_d  = daddr;
                    store_d = dstore;
                    state_d = DSERV;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = GRANT_D;
`endif
                end else if (iREN) begin
                    wr_d    = 1'b0;
                    addr_d  = iaddr;
                    state_d = ISERV;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = GRANT_I;
`endif
                end
            end
            ISERV, DSERV: begin
                cnt_d = cnt_q + 1'b1;
                // ACCESS on the final allowed cycle still completes normally.
                if (ramstate == RAM_ACCESS) begin
                    if (state_q == ISERV) begin
                        iload_d = ramload;
                        state_d = IRESP;
                    end else begin
                        if (!wr_q) begin
                            dload_d = ramload;
                        end
                        state_d = DRESP;
                    end
                end else if ((ramstate == RAM_ERROR) || (cnt_q == CNT_LAST)) begin
                    state_d = ERR;
                end
            end
            IRESP, DRESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = ERR;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            iload_q <= '0;
            dload_q <= '0;
            cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= GRANT_I;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            cnt_q   <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // RAM side is driven purely from latched state so requester changes mid-service are ignored.
    assign ramREN   = ((state_q == ISERV) || (state_q == DSERV)) && !wr_q;
    assign ramWEN   = (state_q == DSERV) && wr_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign iwait    = (state_q != IRESP);
    assign dwait    = (state_q != DRESP);
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign arb_err  = (state_q == ERR);

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: RAM model, vector table, scoreboard of expected responses, error/reset sequences.
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait, ramREN, ramWEN, arb_err;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    memory_arbiter #(.TIMEOUT(4), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM model: mode 0 = ACCESS after ram_lat BUSY cycles, 1 = BUSY forever, 2 = ERROR.
    int          ram_lat  = 0;
    int          ram_mode = 0;
    int          ram_cnt  = 0;
    logic [31:0] ram_rdata = '0;

    always @(posedge CLK) begin
        if (ramREN || ramWEN) ram_cnt <= ram_cnt + 1;
        else                  ram_cnt <= 0;
    end

    always_comb begin
        ramstate = 2'd0;
        if (ramREN || ramWEN) begin
            if (ram_mode == 1)             ramstate = 2'd1;
            else if (ram_mode == 2)        ramstate = 2'd3;
            else if (ram_cnt == ram_lat)   ramstate = 2'd2;
            else                           ramstate = 2'd1;
        end
        ramload = (ramstate == 2'd2) ? ram_rdata : 32'hBAD0_BAD0;
    end

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] load;
        int          due;
        logic [31:0] addr;
        logic [31:0] store;
        int          run;
    } exp_t;

    typedef struct {
        bit          is_d;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        logic [31:0] exp_load;
        int          exp_lat;
    } vec_t;

    exp_t        sb[$];
    int          resp_cnt  = 0;
    bit          both_low  = 0;
    int          run       = 0;
    int          last_run  = 0;
    bit          acc_wen   = 0;
    logic [31:0] acc_addr  = '0;
    logic [31:0] acc_store = '0;

    always @(negedge CLK) begin
        exp_t e;
        if (!iwait && !dwait) both_low = 1;
        if (ramREN || ramWEN) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (ramstate == 2'd2) begin
            acc_wen   = ramWEN;
            acc_addr  = ramaddr;
            acc_store = ramstore;
        end
        if (!iwait || !dwait) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: iwait=%b dwait=%b with no pending request (cycle %0d)",
                         iwait, dwait, cyc);
            end else begin
                e = sb.pop_front();
                chk("resp_port_is_d", {31'd0, !dwait}, {31'd0, e.is_d});
                chk("resp_cycle", cyc, e.due);
                chk("resp_load", e.is_d ? dload : iload, e.load);
                chk("ram_wen", {31'd0, acc_wen}, {31'd0, e.wr});
                chk("ram_addr", acc_addr, e.addr);
                if (e.wr) chk("ram_store", acc_store, e.store);
                chk("ram_en_cycles", last_run, e.run);
            end
            resp_cnt++;
        end
    end

    task automatic wait_resp(input int target, input int budget);
        for (int k = 0; k < budget && resp_cnt < target; k++) begin
            @(posedge CLK); #1;
        end
        chk("resp_arrived", {31'd0, resp_cnt >= target}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   target;
        @(posedge CLK); #1;
        ram_lat   = v.lat;
        ram_mode  = 0;
        ram_rdata = v.wen ? 32'h7777_7777 : v.data;
        if (v.is_d) begin
            dREN = v.ren; dWEN = v.wen; daddr = v.addr; dstore = v.data;
        end else begin
            iREN = 1'b1; iaddr = v.addr;
        end
        e.is_d  = v.is_d;
        e.wr    = v.wen;
        e.load  = v.exp_load;
        e.due   = cyc + v.exp_lat;
        e.addr  = v.addr;
        e.store = v.data;
        e.run   = v.lat + 1;
        target  = resp_cnt + 1;
        sb.push_back(e);
        @(posedge CLK); #1;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'hFFFF_FFFF; daddr = 32'hFFFF_FFFF; dstore = 32'hFFFF_FFFF;
        wait_resp(target, 20);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_mode = 0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int   c0;
        int   target;
        exp_t e;
        vec_t v;

        vecs[0] = '{is_d:1'b0, ren:1'b1, wen:1'b0, addr:32'h0000_0040, data:32'h8C22_0004, lat:2,
                    exp_load:32'h8C22_0004, exp_lat:4};
        vecs[1] = '{is_d:1'b1, ren:1'b1, wen:1'b0, addr:32'h0000_0200, data:32'h1234_5678, lat:1,
                    exp_load:32'h1234_5678, exp_lat:3};
        vecs[2] = '{is_d:1'b1, ren:1'b0, wen:1'b1, addr:32'h0000_0100, data:32'hDEAD_BEEF, lat:0,
                    exp_load:32'h1234_5678, exp_lat:2};
        vecs[3] = '{is_d:1'b0, ren:1'b1, wen:1'b0, addr:32'h0000_0044, data:32'hCAFE_F00D, lat:0,
                    exp_load:32'hCAFE_F00D, exp_lat:2};
        vecs[4] = '{is_d:1'b1, ren:1'b1, wen:1'b1, addr:32'h0000_0300, data:32'h0000_55AA, lat:3,
                    exp_load:32'h1234_5678, exp_lat:5};
        vecs[5] = '{is_d:1'b1, ren:1'b1, wen:1'b0, addr:32'h0000_0304, data:32'hA5A5_0F0F, lat:3,
                    exp_load:32'hA5A5_0F0F, exp_lat:5};

        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        repeat (3) begin @(posedge CLK); #1; end
        chk("rst_iwait", {31'd0, iwait}, 32'd1);
        chk("rst_dwait", {31'd0, dwait}, 32'd1);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_ram_en", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_arb_err", {31'd0, arb_err}, 32'd0);
        RST = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Both ports hold requests: D wins every time (fixed) or alternates D, I (round robin).
        do_reset();
        @(posedge CLK); #1;
        c0 = cyc;
        ram_mode = 0; ram_lat = 0; ram_rdata = 32'h0BAD_F00D;
        iREN = 1'b1; iaddr = 32'h0000_1000;
        dREN = 1'b1; daddr = 32'h0000_2000;
        target = resp_cnt + 5;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            e.is_d = (k % 2 == 0);
`else
            e.is_d = 1'b1;
`endif
            e.wr    = 1'b0;
            e.load  = 32'h0BAD_F00D;
            e.due   = c0 + 2 + 3 * k;
            e.addr  = e.is_d ? 32'h0000_2000 : 32'h0000_1000;
            e.store = '0;
            e.run   = 1;
            sb.push_back(e);
        end
        e.is_d = 1'b0; e.wr = 1'b0; e.load = 32'h0BAD_F00D; e.due = c0 + 14;
        e.addr = 32'h0000_1000; e.store = '0; e.run = 1;
        sb.push_back(e);
        while (cyc < c0 + 10) begin @(posedge CLK); #1; end
        dREN = 1'b0;
        while (cyc < c0 + 13) begin @(posedge CLK); #1; end
        iREN = 1'b0;
        wait_resp(target, 20);

        // Timeout: RAM stays BUSY, ERR after four service cycles and sticky.
        do_reset();
        @(posedge CLK); #1;
        c0 = cyc; ram_mode = 1;
        dREN = 1'b1; daddr = 32'h0000_0500;
        @(posedge CLK); #1;
        dREN = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        chk("tmo_last_serv_ren", {31'd0, ramREN}, 32'd1);
        chk("tmo_last_serv_err", {31'd0, arb_err}, 32'd0);
        @(posedge CLK); #1;
        chk("tmo_err", {31'd0, arb_err}, 32'd1);
        chk("tmo_ram_en", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("tmo_waits", {30'd0, iwait, dwait}, 32'd3);
        iREN = 1'b1; dWEN = 1'b1;
        repeat (5) begin @(posedge CLK); #1; end
        chk("tmo_err_sticky", {31'd0, arb_err}, 32'd1);
        chk("tmo_ram_en_held", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("tmo_waits_held", {30'd0, iwait, dwait}, 32'd3);

        // RAM ERROR during a data write: ERR next cycle, dwait never pulses.
        do_reset();
        @(posedge CLK); #1;
        ram_mode = 2;
        dWEN = 1'b1; daddr = 32'h0000_0700; dstore = 32'h0F0F_0F0F;
        @(posedge CLK); #1;
        dWEN = 1'b0;
        chk("ramerr_wen", {31'd0, ramWEN}, 32'd1);
        chk("ramerr_pre", {31'd0, arb_err}, 32'd0);
        @(posedge CLK); #1;
        chk("ramerr_err", {31'd0, arb_err}, 32'd1);
        chk("ramerr_wen_off", {31'd0, ramWEN}, 32'd0);
        repeat (3) begin @(posedge CLK); #1; end
        chk("ramerr_dwait", {31'd0, dwait}, 32'd1);

        // Reset in the middle of a write, then a clean instruction read.
        do_reset();
        @(posedge CLK); #1;
        ram_mode = 1;
        dWEN = 1'b1; daddr = 32'h0000_0600; dstore = 32'h1111_2222;
        @(posedge CLK); #1;
        dWEN = 1'b0;
        @(posedge CLK); #1;
        chk("mid_wen_before", {31'd0, ramWEN}, 32'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("mid_ram_en", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("mid_ramaddr", ramaddr, 32'd0);
        chk("mid_ramstore", ramstore, 32'd0);
        chk("mid_waits", {30'd0, iwait, dwait}, 32'd3);
        chk("mid_loads", iload | dload, 32'd0);
        chk("mid_arb_err", {31'd0, arb_err}, 32'd0);
        RST = 1'b0; ram_mode = 0;
        v = '{is_d:1'b0, ren:1'b1, wen:1'b0, addr:32'h0000_0048, data:32'h1357_9BDF, lat:1,
              exp_load:32'h1357_9BDF, exp_lat:3};
        run_vec(v);

        repeat (4) begin @(posedge CLK); #1; end
        chk("sb_empty", sb.size(), 32'd0);
        chk("never_both_low", {31'd0, both_low}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule
